dmem_arbiter: RTL and testbench

Single-port data-memory arbiter shared between the pipelined core's MEM stage and a DMA/loader master. Grants at most one access per cycle, core-priority by default, with a starvation counter that forces a DMA grant and a bounded locked-burst mode for DMA. Tracks the one-cycle read response and returns it to its owner. Sits between the EX/MEM register outputs, the DMA port and the data memory; its `core_stall` feeds the hazard unit.

---
 rtl/dmem_arbiter.sv | 140 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the core MEM stage and a DMA master.
// Core-priority with a starvation override, bounded DMA locked bursts, 1-cycle read return.
module dmem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_stall,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    input  logic          dma_lock,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

    typedef enum logic {
        PRI_CORE = 1'b0,
        PRI_DMA  = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    logic [CW-1:0] burst_nxt;
    logic          rsp_v_q, rsp_v_d;
    logic          rsp_core_q, rsp_core_d;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= PRI_CORE;
            starve_cnt_q <= '0;
            burst_cnt_q  <= '0;
            rsp_v_q      <= 1'b0;
            rsp_core_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            rsp_v_q      <= rsp_v_d;
            rsp_core_q   <= rsp_core_d;
        end
    end

    assign burst_nxt = burst_cnt_q + CW'(1);

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        burst_cnt_d  = burst_cnt_q;
        starve_cnt_d = starve_cnt_q;

        if (dma_gnt || !dma_req) begin
            starve_cnt_d = '0;
        end else if (core_gnt && starve_cnt_q != SMAX) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
        end

        case (state_q)
            PRI_DMA: begin
                // A dropped request or an exhausted/unlocked beat hands priority back.
                if (dma_req && dma_lock && burst_nxt < SMAX) begin
                    burst_cnt_d = burst_nxt;
                end else begin
                    state_d     = PRI_CORE;
                    burst_cnt_d = '0;
                end
            end
            default: begin
                if (dma_gnt && dma_lock) begin
                    state_d     = PRI_DMA;
                    burst_cnt_d = CW'(1);
                end
            end
        endcase

        rsp_v_d    = mem_en & ~mem_we;
        rsp_core_d = core_gnt;
    end

    // Output logic; grants are forced low while reset is held.
    always_comb begin
        core_gnt = 1'b0;
        dma_gnt  = 1'b0;
        if (rst) begin
            case (state_q)
                PRI_DMA: begin
                    if (dma_req)       dma_gnt  = 1'b1;
                    else if (core_req) core_gnt = 1'b1;
                end
                default: begin
                    if (core_req && dma_req && starve_cnt_q == SMAX) dma_gnt = 1'b1;
                    else if (core_req)                               core_gnt = 1'b1;
                    else if (dma_req)                                dma_gnt  = 1'b1;
                end
            endcase
        end

        mem_en    = core_gnt | dma_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (core_gnt) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (dma_gnt) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    assign core_stall  = core_req & ~core_gnt;
    assign core_rvalid = rsp_v_q & rsp_core_q;
    assign dma_rvalid  = rsp_v_q & ~rsp_core_q;
    assign core_rdata  = rst ? mem_rdata : '0;
    assign dma_rdata   = rst ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: reset/starvation/burst vector table, hand corner cases,
// then random traffic checked against a cycle-level reference model.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_req, core_we, core_gnt, core_stall, core_rvalid;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata, core_rdata;
    logic          dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata, dma_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rd = '0;

    int errs = 0;
    int checks = 0;

    // reference model state
    bit          m_dpri = 0;
    int          m_wins = 0;
    int          m_beats = 0;
    int          pend = 0;
    logic [31:0] pend_data = '0;

    typedef struct {
        bit cr, cwe, dr, dwe, lk;
        bit ec, ed;
    } vec_t;
    vec_t tbl[$];

    dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_gnt(core_gnt), .core_stall(core_stall),
        .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_lock(dma_lock), .dma_gnt(dma_gnt),
        .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rd)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : ((a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
    endfunction

    // memory with one-cycle read latency
    always @(posedge clk) if (mem_en && !mem_we) mem_rd <= memf(mem_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One cycle, entered just after a negedge with inputs set.
    task automatic step(input bit use_tbl, input bit tc, input bit td, input bit rst_mid);
        bit ec, ed;
        logic [31:0] ea, ew;
        bit ewe;
        #2;
        ec = 0; ed = 0;
        if (rst) begin
            if (m_dpri) begin
                ed = dma_req;
                ec = core_req && !dma_req;
            end else if (core_req && dma_req && m_wins >= SM) ed = 1;
            else if (core_req) ec = 1;
            else ed = dma_req;
        end
        ewe = ec ? core_we : (ed ? dma_we : 1'b0);
        ea  = ec ? core_addr : (ed ? dma_addr : 32'h0);
        ew  = ec ? core_wdata : (ed ? dma_wdata : 32'h0);
        chk("core_gnt", 32'(core_gnt), 32'(ec));
        chk("dma_gnt", 32'(dma_gnt), 32'(ed));
        chk("core_stall", 32'(core_stall), 32'(core_req && !ec));
        chk("mem_en", 32'(mem_en), 32'(ec || ed));
        chk("mem_we", 32'(mem_we), 32'(ewe));
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ew);
        chk("core_rvalid", 32'(core_rvalid), 32'(pend == 1));
        chk("dma_rvalid", 32'(dma_rvalid), 32'(pend == 2));
        if (pend == 1) chk("core_rdata", core_rdata, pend_data);
        if (pend == 2) chk("dma_rdata", dma_rdata, pend_data);
        if (!rst) begin
            chk("core_rdata_rst", core_rdata, 32'h0);
            chk("dma_rdata_rst", dma_rdata, 32'h0);
        end
        if (use_tbl) begin
            chk("tbl_core_gnt", 32'(core_gnt), 32'(tc));
            chk("tbl_dma_gnt", 32'(dma_gnt), 32'(td));
        end
        if (rst_mid) begin
            #1 rst = 1'b0;
        end
        @(posedge clk);
        if (!rst) begin
            m_dpri = 0; m_wins = 0; m_beats = 0; pend = 0;
        end else begin
            if (ed || !dma_req) m_wins = 0;
            else if (ec && m_wins < SM) m_wins++;
            if (!m_dpri) begin
                if (ed && dma_lock) begin
                    m_dpri = 1; m_beats = 1;
                end
            end else if (dma_req && dma_lock && m_beats + 1 < SM) begin
                m_beats++;
            end else begin
                m_dpri = 0; m_beats = 0;
            end
            pend = 0;
            if (ec && !core_we) begin
                pend = 1; pend_data = memf(core_addr);
            end else if (ed && !dma_we) begin
                pend = 2; pend_data = memf(dma_addr);
            end
        end
        @(negedge clk);
    endtask

    task automatic set_in(input bit cr, input bit cwe, input logic [31:0] ca,
                          input bit dr, input bit dwe, input logic [31:0] da, input bit lk);
        core_req = cr; core_we = cwe; core_addr = ca; core_wdata = $urandom;
        dma_req = dr; dma_we = dwe; dma_addr = da; dma_wdata = $urandom; dma_lock = lk;
    endtask

    task automatic add(input bit cr, input bit dr, input bit lk, input bit ec, input bit ed);
        vec_t v;
        v.cr = cr; v.cwe = 0; v.dr = dr; v.dwe = 0; v.lk = lk; v.ec = ec; v.ed = ed;
        tbl.push_back(v);
    endtask

    initial begin
        // starvation: C,C,C,C,D twice
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) add(1, 1, 0, 1, 0);
            add(1, 1, 0, 0, 1);
        end
        // locked burst entered by forced grant: four D beats then core
        for (int i = 0; i < 4; i++) add(1, 1, 1, 1, 0);
        for (int i = 0; i < 4; i++) add(1, 1, 1, 0, 1);
        add(1, 1, 1, 1, 0);
        // burst ended early after 2 beats
        add(0, 1, 1, 0, 1);
        add(1, 1, 1, 0, 1);
        add(1, 0, 0, 1, 0);
        add(1, 1, 0, 1, 0);
        // lock without request is ignored
        add(1, 0, 1, 1, 0);
        add(1, 1, 0, 1, 0);

        rst = 1'b0;
        set_in(1, 0, 32'h40, 1, 0, 32'h80, 0);
        @(negedge clk);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        rst = 1'b1;

        foreach (tbl[i]) begin
            set_in(tbl[i].cr, tbl[i].cwe, 32'h100 + 32'(i) * 4,
                   tbl[i].dr, tbl[i].dwe, 32'h8000 + 32'(i) * 4, tbl[i].lk);
            step(1, tbl[i].ec, tbl[i].ed, 0);
        end

        // solo reads returning DEADBEEF
        set_in(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0);
        set_in(1, 0, 32'h10, 0, 0, 0, 0);
        step(1, 1, 0, 0);
        set_in(0, 0, 0, 0, 0, 0, 0);
        #2 chk("solo_core_rdata", core_rdata, 32'hDEAD_BEEF);
        chk("solo_core_rvalid", 32'(core_rvalid), 32'h1);
        step(0, 0, 0, 0);
        set_in(0, 0, 0, 1, 0, 32'h10, 0);
        step(1, 0, 1, 0);
        set_in(0, 0, 0, 0, 0, 0, 0);
        #2 chk("solo_dma_rdata", dma_rdata, 32'hDEAD_BEEF);
        chk("solo_dma_rvalid", 32'(dma_rvalid), 32'h1);
        step(0, 0, 0, 0);

        // alternating owners back to back
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) set_in(1, 0, 32'h200 + 32'(i), 0, 0, 0, 0);
            else            set_in(0, 0, 0, 1, 0, 32'h300 + 32'(i), 0);
            step(0, 0, 0, 0);
        end

        // reset between a grant and its response
        set_in(1, 0, 32'h444, 0, 0, 0, 0);
        step(0, 0, 0, 1);
        set_in(0, 0, 0, 0, 0, 0, 0);
        #2 chk("rst_drop_rvalid", 32'(core_rvalid | dma_rvalid), 32'h0);
        step(0, 0, 0, 0);
        rst = 1'b1;
        #2 chk("post_rst_rvalid", 32'(core_rvalid | dma_rvalid), 32'h0);
        step(0, 0, 0, 0);

        // random traffic against the model
        for (int i = 0; i < 800; i++) begin
            set_in($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, $urandom,
                   $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3, $urandom,
                   $urandom_range(0, 1) == 1);
            step(0, 0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
